// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter that shares one CCD-sensor I2C write controller between NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to add a watchdog that treats a stuck transfer as a NACK.
module i2c_cmd_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter logic [7:0]  SLAVE_ADDR  = 8'hBA,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [NUM_REQ-1:0]      iREQ,
  input  logic [NUM_REQ*24-1:0]   iREQ_DATA,
  output logic [NUM_REQ-1:0]      oGNT,
  output logic [NUM_REQ-1:0]      oDONE,
  output logic [NUM_REQ-1:0]      oERR,
  output logic                    oBUSY,
  output logic [31:0]             oI2C_DATA,
  output logic                    oI2C_GO,
  input  logic                    iI2C_END,
  input  logic                    iI2C_ACK
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GapW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCheck, StGap} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     cur_q, cur_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          retry_cnt_q, retry_cnt_d;
  logic                retry_pend_q, retry_pend_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
  logic                ack_q, ack_d;
  logic                end_q;
  logic                go_q, go_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d;

  logic                end_rise;
  logic                win_found, found_hi;
  logic [IdxW-1:0]     win_idx, hi_idx, lo_idx;
  logic [23:0]         win_data;

  assign end_rise = iI2C_END & ~end_q;

  // Lowest request at or above rr_ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    win_found = 1'b0;
    found_hi  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (iREQ[k]) begin
        win_found = 1'b1;
        lo_idx    = IdxW'(k);
        if (IdxW'(k) >= rr_ptr_q) begin
          found_hi = 1'b1;
          hi_idx   = IdxW'(k);
        end
      end
    end
    win_idx  = found_hi ? hi_idx : lo_idx;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IdxW'(k) == win_idx) win_data = iREQ_DATA[k*24 +: 24];
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        wd_expired;

  assign wd_d       = (state_q == StIssue) ? wd_q + 32'd1 : 32'd0;
  assign wd_expired = (state_q == StIssue) && (wd_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  logic wd_expired;
  logic unused_timeout_cfg;

  assign wd_expired         = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    rr_ptr_d     = rr_ptr_q;
    data_d       = data_q;
    retry_cnt_d  = retry_cnt_q;
    retry_pend_d = retry_pend_q;
    gap_cnt_d    = gap_cnt_q;
    ack_d        = ack_q;
    go_d         = 1'b0;
    gnt_d        = '0;
    done_d       = '0;
    err_d        = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          cur_d   = win_idx;
          data_d  = {SLAVE_ADDR, win_data};
          gnt_d   = NUM_REQ'(1) << win_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // GO is registered, so it rises the cycle after ISSUE is entered.
        go_d = 1'b1;
        if (end_rise) begin
          ack_d   = iI2C_ACK;
          go_d    = 1'b0;
          state_d = StCheck;
        end else if (wd_expired) begin
          ack_d   = 1'b1;
          go_d    = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!ack_q) begin
          done_d[cur_q] = 1'b1;
        end else if (retry_cnt_q < 4'(MAX_RETRY)) begin
          retry_cnt_d  = retry_cnt_q + 4'd1;
          retry_pend_d = 1'b1;
        end else begin
          err_d[cur_q] = 1'b1;
        end
        gap_cnt_d = '0;
        state_d   = StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYC - 1)) begin
          gap_cnt_d = '0;
          if (retry_pend_q) begin
            retry_pend_d = 1'b0;
            state_d      = StIssue;
          end else begin
            rr_ptr_d    = (cur_q == IdxW'(NUM_REQ - 1)) ? '0 : cur_q + IdxW'(1);
            retry_cnt_d = '0;
            state_d     = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      rr_ptr_q     <= '0;
      data_q       <= '0;
      retry_cnt_q  <= '0;
      retry_pend_q <= 1'b0;
      gap_cnt_q    <= '0;
      ack_q        <= 1'b0;
      end_q        <= 1'b0;
      go_q         <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      rr_ptr_q     <= rr_ptr_d;
      data_q       <= data_d;
      retry_cnt_q  <= retry_cnt_d;
      retry_pend_q <= retry_pend_d;
      gap_cnt_q    <= gap_cnt_d;
      ack_q        <= ack_d;
      end_q        <= iI2C_END;
      go_q         <= go_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign oGNT      = gnt_q;
  assign oDONE     = done_q;
  assign oERR      = err_q;
  assign oBUSY     = (state_q != StIdle);
  assign oI2C_DATA = data_q;
  assign oI2C_GO   = go_q;

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares the single CCD-sensor I2C write controller between NUM_REQ register-write requesters, e.g. the boot config sequencer, the exposure adjust logic and the zoom/readout-mode logic.
- Grants requesters round-robin, frames each 24-bit {sub_addr, data} word with the slave address, and drives the controller GO/END/ACK handshake.
- Retries NACKed transfers and reports done or error per requester.
- Runs in the iCLK domain; the controller-side handshake signals are already synchronised to iCLK.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SLAVE_ADDR, 8'hBA, I2C write address placed in oI2C_DATA[31:24].
- MAX_RETRY, 3, extra attempts after a NACK before error (0..15).
- GAP_CYC, 16, idle iCLK cycles forced between transfers (>=1).
- TIMEOUT_CYC, 2000000, watchdog limit in iCLK cycles (used only with the optional feature).

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  reset; asynchronous, active-low.
- iREQ  in  NUM_REQ  level request; held by the requester until its oDONE or oERR.
- iREQ_DATA  in  NUM_REQ*24  requester k's word in bits [24k+23:24k], stable while iREQ[k]=1.
- oGNT  out  NUM_REQ  one-hot, 1-cycle pulse when requester k's word is latched.
- oDONE  out  NUM_REQ  1-cycle pulse when the write is ACKed.
- oERR  out  NUM_REQ  1-cycle pulse when retries or timeout are exhausted.
- oBUSY  out  1  high in every state except IDLE.
- oI2C_DATA  out  32  {SLAVE_ADDR, latched word}.
- oI2C_GO  out  1  transfer request to the controller.
- iI2C_END  in  1  controller end level; a rising edge marks completion.
- iI2C_ACK  in  1  sampled at END rise; 0 = ACK (success), 1 = NACK.

Behaviour:
- Reset: all outputs 0, oI2C_DATA=0, state IDLE, rr_ptr=0, retry_cnt=0, gap_cnt=0.
- Reset mid-transfer drops GO immediately. No oDONE or oERR is issued for the aborted word.
- IDLE: if any iREQ bit is set, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …).
  - Latch the word and the winner index cur.
  - Pulse oGNT[cur]; go to ISSUE next cycle.
  - Request-to-GO latency is 2 cycles: grant cycle, then GO rises.
- ISSUE:
  - oI2C_GO=1 with oI2C_DATA stable.
  - Edge-detect iI2C_END with a registered previous value.
  - On the rising edge, sample iI2C_ACK, drop GO in the same cycle, go to CHECK.
- CHECK:
  - ACK=0: pulse oDONE[cur], go to GAP.
  - ACK=1 and retry_cnt<MAX_RETRY: increment retry_cnt, go to GAP, then re-issue the same word (no new oGNT).
  - ACK=1 and retry_cnt==MAX_RETRY: pulse oERR[cur], go to GAP.
- GAP:
  - Count GAP_CYC cycles with GO=0; also require iI2C_END=0 or the cycle count elapsed.
  - Then re-enter ISSUE for a pending retry, otherwise IDLE.
  - On leaving for IDLE after a finished word: rr_ptr = (cur+1) mod NUM_REQ, retry_cnt=0.
- Simultaneous requests: exactly one grant per transfer; no requester waits more than NUM_REQ-1 transfers.
- Requests arriving during a transfer wait in IDLE arbitration.
- iREQ deasserted after a grant does not cancel the in-flight word.
- oDONE and oERR are mutually exclusive and occur exactly once per grant.
- A requester must drop iREQ in the cycle after oDONE/oERR or it is re-arbitrated as a new request.
- iI2C_END already high on entry to ISSUE is not a completion; only a 0→1 transition counts.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A 32-bit watchdog counts iCLK cycles in ISSUE and resets on entry to ISSUE.
  - At TIMEOUT_CYC with no END edge: drop GO, treat as a NACK (same retry/error path).
  - Also pulse oERR[cur] on the final failure.
- Undefined: no watchdog; ISSUE waits indefinitely for END.

Test Plan:
- Single request: iREQ=4'b0010, data 24'h09_07C0, controller ACKs after 100 cycles → oGNT[1] pulse, oI2C_DATA=32'hBA0907C0, GO high 2 cycles after request, oDONE[1] one pulse, oBUSY low after GAP_CYC.
- Contention: iREQ=4'b1111 held, rr_ptr=0 → grant order 0,1,2,3,0; exactly one oGNT per transfer.
- NACK retry: ACK=1 twice then 0 with MAX_RETRY=3 → 3 GO assertions, one oGNT, one oDONE, no oERR.
- NACK exhaustion: ACK=1 always → MAX_RETRY+1=4 GO assertions, then one oERR[cur], rr_ptr advances.
- Reset mid-ISSUE: drop iRST_N while GO=1 → GO, oBUSY, and all pulse outputs 0 immediately; after release a held request is re-granted from requester 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=50, END never rises → GO drops after 50 cycles, 4 attempts, then oERR pulse. Same bench without the macro → GO held indefinitely.
